// File: rtl/drac_pkg.sv
// Shared rename-stage types: physical register ids, free-list pointers and checkpoint ids.
// Default sizing for the free list lives here so its users agree on widths.
package drac_pkg;

    localparam int FL_NUM_PHYS_REGS = 64;
    localparam int FL_NUM_ISA_REGS  = 32;
    localparam int FL_NUM_CKPT      = 4;
    localparam int FL_DEPTH_DEF     = FL_NUM_PHYS_REGS - FL_NUM_ISA_REGS;
    localparam int FL_PHREG_W       = $clog2(FL_NUM_PHYS_REGS);
    localparam int FL_PTR_W         = $clog2(FL_DEPTH_DEF) + 1;
    localparam int FL_CKPT_W        = $clog2(FL_NUM_CKPT);

    typedef logic [FL_PHREG_W-1:0] phreg_t;
    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
    typedef logic [FL_CKPT_W-1:0]  fl_ckpt_t;

endpackage

// File: rtl/fl_prefix_count.sv
// Exclusive prefix popcount: offs_o[k] = set bits in vec_i[k-1:0], total_o = popcount(vec_i).
// Purely combinational.
module fl_prefix_count #(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         vec_i,
    output logic [W-1:0][CW-1:0] offs_o,
    output logic [CW-1:0]        total_o
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        offs_o = '0;
        for (int k = 0; k < W; k++) begin
            offs_o[k] = acc;
            acc       = acc + CW'(vec_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/free_list_multiport.sv
// N-wide physical register free list with a ring of head checkpoints for branch recovery.
// Allocation is combinational on the current head; all state updates on clk_i.
module free_list_multiport
    import drac_pkg::*;
#(
    parameter int  NUM_PHYS_REGS = FL_NUM_PHYS_REGS,
    parameter int  NUM_ISA_REGS  = FL_NUM_ISA_REGS,
    parameter int  ALLOC_W       = 2,
    parameter int  FREE_W        = 2,
    parameter int  NUM_CKPT      = FL_NUM_CKPT,
    localparam int PHREG_W       = $clog2(NUM_PHYS_REGS),
    localparam int CKPT_W        = $clog2(NUM_CKPT)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [ALLOC_W-1:0]         alloc_req_i,
    output logic                       alloc_gnt_o,
    output logic [ALLOC_W*PHREG_W-1:0] new_reg_o,
    input  logic [FREE_W-1:0]          free_vld_i,
    input  logic [FREE_W*PHREG_W-1:0]  free_reg_i,
    input  logic                       take_ckpt_i,
    output logic                       ckpt_ok_o,
    output logic [CKPT_W-1:0]          ckpt_id_o,
    input  logic                       delete_ckpt_i,
    input  logic                       recover_i,
    input  logic [CKPT_W-1:0]          recover_id_i,
    input  logic                       flush_i,
    output logic [PHREG_W:0]           free_cnt_o,
    output logic                       empty_o,
    output logic                       out_of_ckpt_o
);

    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ISA_REGS;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int ACW      = $clog2(ALLOC_W + 1);
    localparam int FCW      = $clog2(FREE_W + 1);

    logic [PHREG_W-1:0] table_q [FL_DEPTH];
    logic [PHREG_W-1:0] table_d [FL_DEPTH];
    logic [PTR_W-1:0]   ckpt_head_q [NUM_CKPT];
    logic [PTR_W-1:0]   ckpt_head_d [NUM_CKPT];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CKPT_W-1:0]  cur_q, cur_d, oldest_q, oldest_d, live_q, live_d;

    logic [PTR_W-1:0]             free_cnt, occ_d;
    logic [ALLOC_W-1:0][ACW-1:0]  alloc_offs;
    logic [ACW-1:0]               alloc_n;
    logic [FREE_W-1:0]            free_ok;
    logic [FREE_W-1:0][FCW-1:0]   free_offs;
    logic [FCW-1:0]               free_n;
    logic [FREE_W-1:0][IDX_W-1:0] wr_idx;
    logic                         alloc_gnt, ckpt_ok, del_ok;

    fl_prefix_count #(.W(ALLOC_W)) u_alloc_pfx (
        .vec_i   (alloc_req_i),
        .offs_o  (alloc_offs),
        .total_o (alloc_n)
    );

    fl_prefix_count #(.W(FREE_W)) u_free_pfx (
        .vec_i   (free_ok),
        .offs_o  (free_offs),
        .total_o (free_n)
    );

    assign free_cnt  = tail_q - head_q;
    // Same-cycle frees are not bypassed into the grant decision.
    assign alloc_gnt = (alloc_n != '0) && (PTR_W'(alloc_n) <= free_cnt) && !recover_i && !flush_i;
    assign ckpt_ok   = take_ckpt_i && (live_q < CKPT_W'(NUM_CKPT - 1)) && !recover_i && !flush_i;
    assign del_ok    = delete_ckpt_i && (live_q != '0);

    for (genvar k = 0; k < ALLOC_W; k++) begin : g_alloc
        logic [IDX_W-1:0] rd_idx;
        assign rd_idx = head_q[IDX_W-1:0] + IDX_W'(alloc_offs[k]);
        assign new_reg_o[k*PHREG_W +: PHREG_W] =
            (alloc_gnt && alloc_req_i[k]) ? table_q[rd_idx] : '0;
    end

    // Register 0 is never handed out, so a free of 0 is dropped and the lane compacted away.
    for (genvar j = 0; j < FREE_W; j++) begin : g_free
        assign free_ok[j] = free_vld_i[j] && (free_reg_i[j*PHREG_W +: PHREG_W] != '0) && !flush_i;
        assign wr_idx[j]  = tail_q[IDX_W-1:0] + IDX_W'(free_offs[j]);
    end

    always_comb begin
        table_d = table_q;
        for (int j = 0; j < FREE_W; j++) begin
            if (free_ok[j]) table_d[wr_idx[j]] = free_reg_i[j*PHREG_W +: PHREG_W];
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        cur_d       = cur_q;
        oldest_d    = oldest_q;
        live_d      = live_q;
        ckpt_head_d = ckpt_head_q;
        if (flush_i) begin
            head_d   = {~tail_q[PTR_W-1], tail_q[IDX_W-1:0]};
            cur_d    = '0;
            oldest_d = '0;
            live_d   = '0;
        end else begin
            tail_d = tail_q + PTR_W'(free_n);
            if (alloc_gnt) head_d = head_q + PTR_W'(alloc_n);
            if (del_ok) oldest_d = oldest_q + CKPT_W'(1);
            if (recover_i) begin
                head_d = ckpt_head_q[recover_id_i];
                cur_d  = recover_id_i;
                live_d = recover_id_i - oldest_d;
            end else begin
                live_d = live_q + CKPT_W'(ckpt_ok) - CKPT_W'(del_ok);
                if (ckpt_ok) begin
                    cur_d              = cur_q + CKPT_W'(1);
                    ckpt_head_d[cur_d] = head_d;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FL_DEPTH; i++) table_q[i] <= PHREG_W'(NUM_ISA_REGS + i);
            for (int i = 0; i < NUM_CKPT; i++) ckpt_head_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= {1'b1, {IDX_W{1'b0}}};
            cur_q    <= '0;
            oldest_q <= '0;
            live_q   <= '0;
        end else begin
            table_q     <= table_d;
            ckpt_head_q <= ckpt_head_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cur_q       <= cur_d;
            oldest_q    <= oldest_d;
            live_q      <= live_d;
        end
    end

    assign alloc_gnt_o   = alloc_gnt;
    assign ckpt_ok_o     = ckpt_ok;
    assign ckpt_id_o     = cur_q + CKPT_W'(1);
    assign free_cnt_o    = (PHREG_W + 1)'(free_cnt);
    assign empty_o       = (free_cnt == '0);
    assign out_of_ckpt_o = (live_q == CKPT_W'(NUM_CKPT - 1));

    // More registers in flight than the list can hold means a double free upstream.
    assign occ_d = tail_d - head_d;
    a_no_overfill: assert property (@(posedge clk_i) disable iff (!rstn_i)
        occ_d <= PTR_W'(FL_DEPTH));

endmodule

// File: tb/tb_free_list_multiport.sv
// Randomised and directed stimulus for free_list_multiport against an integer-pointer reference model;
// expected per-cycle outputs are queued by the driver and popped by an independent monitor.
module tb_free_list_multiport;
    import drac_pkg::*;

    localparam int AW    = 2;
    localparam int FW    = 2;
    localparam int PW    = FL_PHREG_W;
    localparam int CW    = FL_CKPT_W;
    localparam int DEPTH = FL_DEPTH_DEF;
    localparam int NCK   = FL_NUM_CKPT;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [AW-1:0]  alloc_req_i;
    logic           alloc_gnt_o;
    logic [AW*PW-1:0] new_reg_o;
    logic [FW-1:0]  free_vld_i;
    logic [FW*PW-1:0] free_reg_i;
    logic           take_ckpt_i, ckpt_ok_o;
    fl_ckpt_t       ckpt_id_o;
    logic           delete_ckpt_i, recover_i, flush_i;
    fl_ckpt_t       recover_id_i;
    logic [PW:0]    free_cnt_o;
    logic           empty_o, out_of_ckpt_o;

    always #5 clk_i = ~clk_i;

    free_list_multiport dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .alloc_req_i   (alloc_req_i),
        .alloc_gnt_o   (alloc_gnt_o),
        .new_reg_o     (new_reg_o),
        .free_vld_i    (free_vld_i),
        .free_reg_i    (free_reg_i),
        .take_ckpt_i   (take_ckpt_i),
        .ckpt_ok_o     (ckpt_ok_o),
        .ckpt_id_o     (ckpt_id_o),
        .delete_ckpt_i (delete_ckpt_i),
        .recover_i     (recover_i),
        .recover_id_i  (recover_id_i),
        .flush_i       (flush_i),
        .free_cnt_o    (free_cnt_o),
        .empty_o       (empty_o),
        .out_of_ckpt_o (out_of_ckpt_o)
    );

    typedef struct {
        logic           gnt;
        logic [AW*PW-1:0] regs;
        int             cnt;
        logic           empty;
        logic           ok;
        int             id;
        logic           ooc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference model: unbounded integer head/tail, contents indexed modulo the depth.
    phreg_t mem [DEPTH];
    int m_head, m_tail, m_cur, m_old, m_live;
    int m_ck [NCK];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = phreg_t'(FL_NUM_ISA_REGS + i);
        for (int i = 0; i < NCK; i++) m_ck[i] = 0;
        m_head = 0;
        m_tail = DEPTH;
        m_cur  = 0;
        m_old  = 0;
        m_live = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int   n, cnt, off;
        bit   del;
        cnt     = m_tail - m_head;
        n       = $countones(alloc_req_i);
        e.gnt   = (n != 0) && (n <= cnt) && !recover_i && !flush_i;
        e.regs  = '0;
        off     = 0;
        for (int k = 0; k < AW; k++) begin
            if (alloc_req_i[k]) begin
                if (e.gnt) e.regs[k*PW +: PW] = mem[(m_head + off) % DEPTH];
                off++;
            end
        end
        e.cnt   = cnt;
        e.empty = (cnt == 0);
        e.ok    = take_ckpt_i && (m_live < NCK - 1) && !recover_i && !flush_i;
        e.id    = (m_cur + 1) % NCK;
        e.ooc   = (m_live == NCK - 1);
        exp_q.push_back(e);
        if (flush_i) begin
            m_head = m_tail - DEPTH;
            m_cur  = 0;
            m_old  = 0;
            m_live = 0;
        end else begin
            for (int j = 0; j < FW; j++) begin
                if (free_vld_i[j] && free_reg_i[j*PW +: PW] != '0) begin
                    mem[m_tail % DEPTH] = free_reg_i[j*PW +: PW];
                    m_tail++;
                end
            end
            if (e.gnt) m_head += n;
            del = delete_ckpt_i && (m_live > 0);
            if (del) m_old = (m_old + 1) % NCK;
            if (recover_i) begin
                m_head = m_ck[recover_id_i];
                m_cur  = int'(recover_id_i);
                m_live = (int'(recover_id_i) - m_old + NCK) % NCK;
            end else begin
                if (e.ok) begin
                    m_cur       = (m_cur + 1) % NCK;
                    m_ck[m_cur] = m_head;
                end
                m_live = m_live + int'(e.ok) - int'(del);
            end
        end
    endtask

    task automatic idle();
        alloc_req_i   = '0;
        free_vld_i    = '0;
        free_reg_i    = '0;
        take_ckpt_i   = 1'b0;
        delete_ckpt_i = 1'b0;
        recover_i     = 1'b0;
        recover_id_i  = '0;
        flush_i       = 1'b0;
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rstn_i = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk_i);
        #2;
        check("rst_free_cnt", free_cnt_o, 32);
        check("rst_empty", empty_o, 0);
        check("rst_ckpt_id", ckpt_id_o, 1);
        check("rst_gnt", alloc_gnt_o, 0);
        check("rst_new_reg", new_reg_o, 0);
        check("rst_ooc", out_of_ckpt_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    // Monitor: one expected record per active cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rstn_i && !done) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("alloc_gnt", alloc_gnt_o, e.gnt);
                    check("new_reg", new_reg_o, e.regs);
                    check("free_cnt", free_cnt_o, e.cnt);
                    check("empty", empty_o, e.empty);
                    check("ckpt_ok", ckpt_ok_o, e.ok);
                    check("ckpt_id", ckpt_id_o, e.id);
                    check("out_of_ckpt", out_of_ckpt_o, e.ooc);
                end
            end
        end
    end

    initial begin
        int n, cnt, nf, id;
        bit g;
        rstn_i = 1'b0;
        do_reset();

        // Two-lane allocation right after reset.
        alloc_req_i = 2'b11;
        model_step(); #2;
        check("t1_new_reg", new_reg_o, {6'd33, 6'd32});
        @(negedge clk_i);
        idle();
        check("t1_free_cnt", free_cnt_o, 30);

        // Drain to one entry, then a 2-lane request is refused while a free lands.
        for (int i = 0; i < 14; i++) begin alloc_req_i = 2'b11; cyc(); end
        alloc_req_i = 2'b01; cyc();
        alloc_req_i = 2'b11;
        free_vld_i  = 2'b01;
        free_reg_i  = {6'd0, 6'd5};
        model_step(); #2;
        check("t2_no_gnt", alloc_gnt_o, 0);
        @(negedge clk_i);
        idle();
        check("t2_free_cnt", free_cnt_o, 2);

        // Register 0 free is dropped; refill across the wrap, then drain to empty.
        free_vld_i = 2'b11;
        free_reg_i = {6'd0, 6'd7};
        cyc();
        idle();
        check("t3_free_cnt", free_cnt_o, 3);
        while (m_tail - m_head < DEPTH) begin
            idle();
            free_vld_i = (DEPTH - (m_tail - m_head) >= 2) ? 2'b11 : 2'b01;
            for (int j = 0; j < FW; j++) free_reg_i[j*PW +: PW] = PW'($urandom_range(1, 63));
            cyc();
        end
        idle();
        check("t3_full", free_cnt_o, 32);
        for (int i = 0; i < 16; i++) begin alloc_req_i = 2'b11; cyc(); end
        idle();
        check("t3_empty", empty_o, 1);
        alloc_req_i = 2'b01; cyc();

        // Checkpoint at head=4, allocate past it, recover.
        do_reset();
        alloc_req_i = 2'b11; cyc();
        alloc_req_i = 2'b11;
        take_ckpt_i = 1'b1;
        model_step(); #2;
        check("t4_ckpt_ok", ckpt_ok_o, 1);
        check("t4_ckpt_id", ckpt_id_o, 1);
        @(negedge clk_i);
        idle();
        for (int i = 0; i < 3; i++) begin alloc_req_i = 2'b11; cyc(); end
        idle();
        recover_i    = 1'b1;
        recover_id_i = 2'd1;
        cyc();
        idle();
        check("t4_restored_cnt", free_cnt_o, 28);

        // Fill the checkpoint ring.
        take_ckpt_i = 1'b1; cyc();
        take_ckpt_i = 1'b1; cyc();
        idle();
        check("t5_out_of_ckpt", out_of_ckpt_o, 1);
        take_ckpt_i = 1'b1;
        model_step(); #2;
        check("t5_ckpt_refused", ckpt_ok_o, 0);
        @(negedge clk_i);
        delete_ckpt_i = 1'b1;
        take_ckpt_i   = 1'b1;
        cyc();
        idle();
        check("t5_after_delete", out_of_ckpt_o, 0);
        delete_ckpt_i = 1'b1;
        take_ckpt_i   = 1'b1;
        model_step(); #2;
        check("t5_del_take_ok", ckpt_ok_o, 1);
        @(negedge clk_i);
        idle();
        check("t5_live_kept", out_of_ckpt_o, 0);

        // Flush overrides everything else issued in the same cycle.
        alloc_req_i = 2'b11;
        free_vld_i  = 2'b01;
        free_reg_i  = {6'd0, 6'd9};
        take_ckpt_i = 1'b1;
        flush_i     = 1'b1;
        model_step(); #2;
        check("t6_no_gnt", alloc_gnt_o, 0);
        check("t6_no_ckpt", ckpt_ok_o, 0);
        @(negedge clk_i);
        idle();
        check("t6_full", free_cnt_o, 32);
        check("t6_ckpt_id", ckpt_id_o, 1);
        check("t6_live", out_of_ckpt_o, 0);

        // Random traffic, constrained only to stay within a legal occupancy.
        for (int c = 0; c < 3000; c++) begin
            idle();
            alloc_req_i   = AW'($urandom_range(0, 3));
            take_ckpt_i   = ($urandom_range(0, 5) == 0);
            delete_ckpt_i = ($urandom_range(0, 5) == 0);
            free_vld_i    = FW'($urandom_range(0, 3));
            for (int j = 0; j < FW; j++)
                free_reg_i[j*PW +: PW] = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 63));
            if ($urandom_range(0, 99) < 2) begin
                flush_i = 1'b1;
            end else if ($urandom_range(0, 99) < 8) begin
                id = $urandom_range(0, NCK - 1);
                if (m_tail - m_ck[id] >= 0 && m_tail - m_ck[id] <= DEPTH) begin
                    recover_i    = 1'b1;
                    recover_id_i = CW'(id);
                    free_vld_i   = '0;
                end
            end
            n   = $countones(alloc_req_i);
            cnt = m_tail - m_head;
            g   = (n != 0) && (n <= cnt) && !recover_i && !flush_i;
            nf  = 0;
            for (int j = 0; j < FW; j++)
                if (free_vld_i[j] && free_reg_i[j*PW +: PW] != '0) nf++;
            if (!flush_i && (cnt - (g ? n : 0) + nf > DEPTH)) free_vld_i = '0;
            cyc();
        end
        idle();
        cyc();
        done = 1'b1;
        #5;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
